// File: rtl/sobel_pio_pkg.sv
// Shared widths, command/status field positions, opcode and FSM state types for the Sobel PIO engine.
package sobel_pio_pkg;

    localparam int unsigned CMD_W  = 19;
    localparam int unsigned STS_W  = 11;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned N_PIX  = 9;
    localparam int unsigned WIN_W  = PIX_W * N_PIX;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned GRAD_W = 11;
    localparam int unsigned ABS_W  = 10;
    localparam int unsigned MAG_W  = 12;

    localparam int unsigned CMD_REQ_BIT  = 18;
    localparam int unsigned CMD_OP_LSB   = 16;
    localparam int unsigned CMD_IDX_LSB  = 12;
    localparam int unsigned CMD_DATA_LSB = 0;

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_PIX - 1);

    typedef enum logic [OP_W-1:0] {
        OP_CLEAR = 2'b00,
        OP_WRITE = 2'b01,
        OP_START = 2'b10,
        OP_READ  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_CALC1 = 3'd2,
        S_CALC2 = 3'd3,
        S_CALC3 = 3'd4,
        S_ACKW  = 3'd5
    } state_e;

    // Status word as read back by the HPS: [10]ACK [9]BUSY [8]ERR [7:0]RESULT
    typedef struct packed {
        logic             ack;
        logic             busy;
        logic             err;
        logic [PIX_W-1:0] result;
    } sts_t;

    function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
        return idx <= IDX_MAX;
    endfunction

endpackage

// File: rtl/sobel3x3_core.sv
// Three-stage Sobel gradient pipeline: partial sums, absolute values, magnitude + output mapping.
// Output mapping selected by SOBEL_THRESHOLD_EN (binary edge map) or saturated magnitude by default.
module sobel3x3_core
    import sobel_pio_pkg::*;
#(
    parameter logic [PIX_W-1:0] THRESH = 8'd128
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIN_W-1:0] i_win,
    input  logic             i_en1,
    input  logic             i_en2,
    output logic [PIX_W-1:0] o_result_c
);

    logic [PIX_W-1:0]         w_p [N_PIX];
    logic [ABS_W-1:0]         w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic signed [GRAD_W-1:0] w_gx, w_gy;
    logic signed [GRAD_W-1:0] r_gx, r_gy;
    logic [ABS_W-1:0]         r_ax, r_ay;
    logic [MAG_W-1:0]         w_mag;

    always_comb begin
        for (int k = 0; k < int'(N_PIX); k++) begin
            w_p[k] = i_win[k*PIX_W +: PIX_W];
        end
    end

    // Each one-sided sum peaks at 1020, so 10 unsigned bits hold it exactly
    always_comb begin
        w_gx_pos = ABS_W'(w_p[2]) + (ABS_W'(w_p[5]) << 1) + ABS_W'(w_p[8]);
        w_gx_neg = ABS_W'(w_p[0]) + (ABS_W'(w_p[3]) << 1) + ABS_W'(w_p[6]);
        w_gy_pos = ABS_W'(w_p[6]) + (ABS_W'(w_p[7]) << 1) + ABS_W'(w_p[8]);
        w_gy_neg = ABS_W'(w_p[0]) + (ABS_W'(w_p[1]) << 1) + ABS_W'(w_p[2]);
        w_gx     = $signed({1'b0, w_gx_pos}) - $signed({1'b0, w_gx_neg});
        w_gy     = $signed({1'b0, w_gy_pos}) - $signed({1'b0, w_gy_neg});
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gx <= '0;
            r_gy <= '0;
            r_ax <= '0;
            r_ay <= '0;
        end else begin
            if (i_en1) begin
                r_gx <= w_gx;
                r_gy <= w_gy;
            end
            if (i_en2) begin
                r_ax <= r_gx[GRAD_W-1] ? ABS_W'(-r_gx) : ABS_W'(r_gx);
                r_ay <= r_gy[GRAD_W-1] ? ABS_W'(-r_gy) : ABS_W'(r_gy);
            end
        end
    end

    assign w_mag = MAG_W'(r_ax) + MAG_W'(r_ay);

`ifdef SOBEL_THRESHOLD_EN
    assign o_result_c = (w_mag >= MAG_W'(THRESH)) ? 8'hFF : 8'h00;
`else
    logic [PIX_W-1:0] w_unused_thresh;
    assign w_unused_thresh = THRESH;
    assign o_result_c = (w_mag > MAG_W'(255)) ? 8'hFF : w_mag[PIX_W-1:0];
`endif

endmodule

// File: rtl/sobel_pio_engine.sv
// HPS command/compute stage: 4-phase REQ/ACK handshake, 3x3 window register file, Sobel launch.
// Build option SOBEL_THRESHOLD_EN selects the binary edge-map output of the core.
module sobel_pio_engine
    import sobel_pio_pkg::*;
#(
    parameter logic [PIX_W-1:0] THRESH   = 8'd128,
    parameter bit               REQ_SYNC = 1'b0
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [CMD_W-1:0] cmd_word,
    output logic [STS_W-1:0] sts_word
);

    state_e           r_state, w_state_nxt;
    logic             w_req_raw, w_req;
    op_e              w_op, r_op;
    logic [IDX_W-1:0] w_idx, r_idx;
    logic [PIX_W-1:0] w_data, r_data;
    logic             w_unused_rsvd;

    logic             w_accept, w_exec, w_en1, w_en2, w_fin, w_release;
    logic [PIX_W-1:0] r_win [N_PIX];
    logic [WIN_W-1:0] w_win_flat;
    logic [PIX_W-1:0] w_core_res_c;

    logic             r_ack, r_busy, r_err;
    logic [PIX_W-1:0] r_result;
    sts_t             w_sts;

    assign w_req_raw     = cmd_word[CMD_REQ_BIT];
    assign w_op          = op_e'(cmd_word[CMD_OP_LSB +: OP_W]);
    assign w_idx         = cmd_word[CMD_IDX_LSB +: IDX_W];
    assign w_data        = cmd_word[CMD_DATA_LSB +: PIX_W];
    assign w_unused_rsvd = ^cmd_word[CMD_IDX_LSB-1 : CMD_DATA_LSB+PIX_W];

    // Optional REQ synchronizer; command fields are stable while REQ is high so only REQ is resynced
    generate
        if (REQ_SYNC) begin : g_req_sync
            logic r_req_s1, r_req_s2;
            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    r_req_s1 <= 1'b0;
                    r_req_s2 <= 1'b0;
                end else begin
                    r_req_s1 <= w_req_raw;
                    r_req_s2 <= r_req_s1;
                end
            end
            assign w_req = r_req_s2;
        end else begin : g_req_direct
            assign w_req = w_req_raw;
        end
    endgenerate

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_exec      = 1'b0;
        w_en1       = 1'b0;
        w_en2       = 1'b0;
        w_fin       = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = (r_op == OP_START) ? S_CALC1 : S_ACKW;
            end
            S_CALC1: begin
                w_en1       = 1'b1;
                w_state_nxt = S_CALC2;
            end
            S_CALC2: begin
                w_en2       = 1'b1;
                w_state_nxt = S_CALC3;
            end
            S_CALC3: begin
                w_fin       = 1'b1;
                w_state_nxt = S_ACKW;
            end
            S_ACKW: begin
                if (!w_req) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_op   <= OP_CLEAR;
            r_idx  <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_op   <= w_op;
            r_idx  <= w_idx;
            r_data <= w_data;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < int'(N_PIX); i++) begin
                r_win[i] <= '0;
            end
        end else if (w_exec) begin
            if (r_op == OP_CLEAR) begin
                for (int i = 0; i < int'(N_PIX); i++) begin
                    r_win[i] <= '0;
                end
            end else if (r_op == OP_WRITE && idx_valid(r_idx)) begin
                r_win[r_idx] <= r_data;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < int'(N_PIX); k++) begin
            w_win_flat[k*PIX_W +: PIX_W] = r_win[k];
        end
    end

    sobel3x3_core #(
        .THRESH (THRESH)
    ) u_core (
        .i_clk      (clk_clk),
        .i_rst      (reset_reset),
        .i_win      (w_win_flat),
        .i_en1      (w_en1),
        .i_en2      (w_en2),
        .o_result_c (w_core_res_c)
    );

    // ACK is raised on entry to ACKW so RESULT and ACK change on the same edge
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_err  <= 1'b0;
                r_busy <= 1'b1;
            end
            if (w_exec) begin
                case (r_op)
                    OP_CLEAR: begin
                        r_result <= '0;
                        r_ack    <= 1'b1;
                    end
                    OP_WRITE: begin
                        r_err <= !idx_valid(r_idx);
                        r_ack <= 1'b1;
                    end
                    OP_READ: begin
                        if (idx_valid(r_idx)) begin
                            r_result <= r_win[r_idx];
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_ack <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (w_fin) begin
                r_result <= w_core_res_c;
                r_ack    <= 1'b1;
            end
            if (w_release) begin
                r_ack  <= 1'b0;
                r_busy <= 1'b0;
            end
        end
    end

    always_comb begin
        w_sts.ack    = r_ack;
        w_sts.busy   = r_busy;
        w_sts.err    = r_err;
        w_sts.result = r_result;
    end

    assign sts_word = w_sts;

endmodule

// File: tb/tb_sobel_pio_engine.sv
// Directed, table-driven bench for sobel_pio_engine: command vectors plus handshake/reset corner cases.
module tb_sobel_pio_engine;

    localparam logic [1:0] CL = 2'b00;
    localparam logic [1:0] WR = 2'b01;
    localparam logic [1:0] ST = 2'b10;
    localparam logic [1:0] RD = 2'b11;

    typedef struct {
        logic [1:0] op;
        logic [3:0] idx;
        logic [7:0] data;
        logic [7:0] exp_res;
        logic       exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] cmd = '0;
    logic [10:0] sts;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[$];

    wire       s_ack  = sts[10];
    wire       s_busy = sts[9];
    wire       s_err  = sts[8];
    wire [7:0] s_res  = sts[7:0];

    sobel_pio_engine dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .cmd_word    (cmd),
        .sts_word    (sts)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pick(input logic [7:0] sat_v, input logic [7:0] thr_v);
`ifdef SOBEL_THRESHOLD_EN
        return thr_v;
`else
        return sat_v;
`endif
    endfunction

    task automatic add(input logic [1:0] op, input logic [3:0] idx, input logic [7:0] data,
                       input logic [7:0] res, input logic err);
        vec_t v;
        v.op = op; v.idx = idx; v.data = data; v.exp_res = res; v.exp_err = err;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int id, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got 0x%0h, expected 0x%0h", nm, id, got, exp);
        end
    endtask

    // Counts edges from the accepting edge (cycle 0); returns the cycle ACK becomes visible, -1 on timeout
    task automatic wait_ack(input int id, output int lat);
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (k == 0) chk("cycle0_ack_busy_err", id, int'({s_ack, s_busy, s_err}), 3'b010);
            if (s_ack) begin
                lat = k + 1;
                break;
            end
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] idx, input logic [7:0] data,
                        input logic [7:0] exp_res, input logic exp_err, input int id);
        int lat;
        @(negedge clk);
        cmd = {1'b1, op, idx, 4'h0, data};
        wait_ack(id, lat);
        chk("ack_latency", id, lat, (op == ST) ? 5 : 2);
        chk("result", id, int'(s_res), int'(exp_res));
        chk("err", id, int'(s_err), int'(exp_err));
        @(negedge clk);
        cmd[18] = 1'b0;
        @(posedge clk); #1;
        chk("release_ack_busy", id, int'({s_ack, s_busy}), 0);
    endtask

    initial begin
        int lat, ack_cnt, rises;
        logic prev, stuck;

        add(WR, 4, 8'h5A, 8'h00, 0);
        add(RD, 4, 8'h00, 8'h5A, 0);
        add(CL, 0, 8'h00, 8'h00, 0);
        add(WR, 2, 8'hFF, 8'h00, 0);
        add(WR, 5, 8'hFF, 8'h00, 0);
        add(WR, 8, 8'hFF, 8'h00, 0);
        add(ST, 0, 8'h00, 8'hFF, 0);
        add(CL, 0, 8'h00, 8'h00, 0);
        add(WR, 5, 8'h0A, 8'h00, 0);
        add(ST, 0, 8'h00, pick(8'h14, 8'h00), 0);
        add(RD, 5, 8'h00, 8'h0A, 0);
        for (int i = 0; i < 9; i++) add(WR, 4'(i), 8'd100, 8'h0A, 0);
        add(ST, 0, 8'h00, 8'h00, 0);
        add(CL, 0, 8'h00, 8'h00, 0);
        add(RD, 0, 8'h00, 8'h00, 0);
        add(WR, 4, 8'h77, 8'h00, 0);
        add(WR, 9, 8'h33, 8'h00, 1);
        add(RD, 4, 8'h00, 8'h77, 0);
        add(RD, 15, 8'h00, 8'h77, 1);
        add(RD, 0, 8'h00, 8'h00, 0);
        add(WR, 0, 8'd50, 8'h00, 0);
        add(WR, 1, 8'd20, 8'h00, 0);
        add(ST, 0, 8'h00, pick(8'h8C, 8'hFF), 0);
        add(CL, 0, 8'h00, 8'h00, 0);
        add(WR, 5, 8'd127, 8'h00, 0);
        add(ST, 0, 8'h00, pick(8'hFE, 8'hFF), 0);
        add(WR, 5, 8'd128, pick(8'hFE, 8'hFF), 0);
        add(ST, 0, 8'h00, 8'hFF, 0);
        add(WR, 5, 8'd63, 8'hFF, 0);
        add(ST, 0, 8'h00, pick(8'h7E, 8'h00), 0);
        add(WR, 5, 8'd64, pick(8'h7E, 8'h00), 0);
        add(ST, 0, 8'h00, pick(8'h80, 8'hFF), 0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_sts", 0, int'(sts), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) send(tbl[i].op, tbl[i].idx, tbl[i].data, tbl[i].exp_res, tbl[i].exp_err, i);

        // REQ dropped right after acceptance: op completes, ACK for one cycle only
        @(negedge clk);
        cmd = {1'b1, WR, 4'd3, 4'h0, 8'h21};
        @(posedge clk);
        @(negedge clk);
        cmd[18] = 1'b0;
        ack_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (s_ack) ack_cnt++;
        end
        chk("early_drop_ack_cycles", 100, ack_cnt, 1);
        chk("early_drop_idle_busy", 100, int'(s_busy), 0);
        send(RD, 3, 8'h00, 8'h21, 0, 101);

        // REQ held 20 cycles past ACK: single execution, ACK/BUSY stay high
        @(negedge clk);
        cmd = {1'b1, ST, 4'h0, 4'h0, 8'h00};
        wait_ack(102, lat);
        chk("held_ack_latency", 102, lat, 5);
        chk("held_result", 102, int'(s_res), int'(pick(8'h3E, 8'h00)));
        rises = 0;
        stuck = 1'b1;
        prev  = s_ack;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (s_ack && !prev) rises++;
            if (!(s_ack && s_busy)) stuck = 1'b0;
            prev = s_ack;
        end
        chk("held_retrigger", 102, rises, 0);
        chk("held_ack_busy_high", 102, int'(stuck), 1);
        @(negedge clk);
        cmd[18] = 1'b0;
        @(posedge clk); #1;
        chk("held_release", 102, int'({s_ack, s_busy}), 0);

        // Reset during START cycle 3, REQ kept high so the command is re-accepted after reset
        @(negedge clk);
        cmd = {1'b1, ST, 4'h0, 4'h0, 8'h00};
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midop_reset_sts", 103, int'(sts), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_ack(103, lat);
        chk("post_reset_latency", 103, lat, 5);
        chk("post_reset_result", 103, int'(s_res), 0);
        @(negedge clk);
        cmd[18] = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_release", 103, int'({s_ack, s_busy}), 0);
        send(RD, 3, 8'h00, 8'h00, 0, 104);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
